// File: rtl/m_stopwatch_ctrl.sv
`timescale 1ns/1ps
// Stopwatch control FSM (IDLE/RUN/STOP/LAP) and BCD mm:ss.cc counter driven by 10 ms ticks.
// 1-cycle latency from a sampled press or tick to registered outputs; no backpressure.
module m_stopwatch_ctrl #(
  parameter int P_MIN_MAX = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk10ms,
  input  logic        i_start_stop,
  input  logic        i_lap_reset,
  output logic        o_gen_rst_n,
  output logic [23:0] o_disp,
  output logic        o_running,
  output logic        o_lap_hold,
  output logic        o_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_LAP} state_t;

  localparam logic [3:0] MIN_T = 4'(P_MIN_MAX / 10);
  localparam logic [3:0] MIN_O = 4'(P_MIN_MAX % 10);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d, cnt_inc;
  logic [23:0] lap_q, lap_d;
  logic        ovf_d, wrap;
  logic        tick_prev_q, ss_prev_q, lr_prev_q;
  logic        tick, press_ss, press_lr;

  assign tick     = clk10ms & ~tick_prev_q;
  assign press_ss = i_start_stop & ~ss_prev_q;
  assign press_lr = i_lap_reset & ~lr_prev_q;

  // Ripple-carry BCD increment: cs_o, cs_t, sec_o, sec_t, then minutes up to P_MIN_MAX.
  always_comb begin
    cnt_inc = cnt_q;
    wrap    = 1'b0;
    if (cnt_q[3:0] != 4'd9) begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] != 4'd9) begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (cnt_q[11:8] != 4'd9) begin
          cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_inc[11:8] = 4'd0;
          if (cnt_q[15:12] != 4'd5) begin
            cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
          end else begin
            cnt_inc[15:12] = 4'd0;
            if (cnt_q[23:16] == {MIN_T, MIN_O}) begin
              cnt_inc[23:16] = 8'd0;
              wrap           = 1'b1;
            end else if (cnt_q[19:16] != 4'd9) begin
              cnt_inc[19:16] = cnt_q[19:16] + 4'd1;
            end else begin
              cnt_inc[19:16] = 4'd0;
              cnt_inc[23:20] = cnt_q[23:20] + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    ovf_d   = o_overflow;
    // Counting uses the pre-transition state, so a tick alongside a stop press still lands.
    if (tick && (state_q == S_RUN || state_q == S_LAP)) begin
      cnt_d = cnt_inc;
      if (wrap) ovf_d = 1'b1;
    end
    case (state_q)
      S_IDLE: if (press_ss) state_d = S_RUN;
      S_RUN: begin
        if (press_ss) begin
          state_d = S_STOP;
        end else if (press_lr) begin
          state_d = S_LAP;
          lap_d   = cnt_q;
        end
      end
      S_LAP: begin
        if (press_ss)      state_d = S_STOP;
        else if (press_lr) state_d = S_RUN;
      end
      S_STOP: begin
        if (press_ss) begin
          state_d = S_RUN;
        end else if (press_lr) begin
          state_d = S_IDLE;
          cnt_d   = 24'd0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 24'd0;
      lap_q       <= 24'd0;
      tick_prev_q <= 1'b1;
      ss_prev_q   <= 1'b1;
      lr_prev_q   <= 1'b1;
      o_disp      <= 24'd0;
      o_gen_rst_n <= 1'b0;
      o_running   <= 1'b0;
      o_lap_hold  <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lap_q       <= lap_d;
      tick_prev_q <= clk10ms;
      ss_prev_q   <= i_start_stop;
      lr_prev_q   <= i_lap_reset;
      o_disp      <= (state_d == S_LAP) ? lap_d : cnt_d;
      o_gen_rst_n <= (state_d != S_IDLE);
      o_running   <= (state_d == S_RUN) || (state_d == S_LAP);
      o_lap_hold  <= (state_d == S_LAP);
      o_overflow  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_m_stopwatch_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for m_stopwatch_ctrl: directed presses and ticks with hand-computed expectations.
module tb_m_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk10ms = 1'b0;
  logic        ss = 1'b0;
  logic        lr = 1'b0;
  logic        o_gen_rst_n;
  logic [23:0] o_disp;
  logic        o_running;
  logic        o_lap_hold;
  logic        o_overflow;

  always #10 clk = ~clk;

  // Small minute limit keeps the wrap test within a short run.
  m_stopwatch_ctrl #(.P_MIN_MAX(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk10ms      (clk10ms),
    .i_start_stop (ss),
    .i_lap_reset  (lr),
    .o_gen_rst_n  (o_gen_rst_n),
    .o_disp       (o_disp),
    .o_running    (o_running),
    .o_lap_hold   (o_lap_hold),
    .o_overflow   (o_overflow)
  );

  typedef struct {
    string       name;
    logic [27:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  wire [27:0] act = {o_disp, o_running, o_lap_hold, o_overflow, o_gen_rst_n};

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got disp=%h run=%b lap=%b ovf=%b gen=%b, want disp=%h run=%b lap=%b ovf=%b gen=%b",
                   e.name, act[27:4], act[3], act[2], act[1], act[0],
                   e.exp[27:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [23:0] d,
                            input bit run, input bit lap, input bit ovf, input bit gen);
    exp_t e;
    e.name = name;
    e.exp  = {d, run, lap, ovf, gen};
    sb_q.push_back(e);
    for (int k = 0; k < 4 && sb_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: monitor did not consume expectation (queue depth %0d, want 0)", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic press(input bit s, input bit l, input bit t);
    ss = s; lr = l; clk10ms = t;
    @(posedge clk); #1;
    ss = 1'b0; lr = 1'b0; clk10ms = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) press(1'b0, 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset with start button and clock wave held high.
    ss = 1'b1; clk10ms = 1'b1;
    expect_out("reset_values", 24'h000000, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("held_across_reset", 24'h000000, 0, 0, 0, 0);
    ss = 1'b0; clk10ms = 1'b0;
    @(posedge clk); #1;
    // A 4-cycle hold must act once: a level-sensitive bug would land back in STOP/IDLE parity.
    ss = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ss = 1'b0;
    @(posedge clk); #1;
    expect_out("held_one_transition", 24'h000000, 1, 0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    expect_out("back_to_idle", 24'h000000, 0, 0, 0, 0);

    // Run/stop.
    press(1, 0, 0);
    ticks(150);
    expect_out("run_150", 24'h000150, 1, 0, 0, 1);
    press(1, 0, 0);
    ticks(40);
    expect_out("stop_holds", 24'h000150, 0, 0, 0, 1);
    press(1, 0, 0);
    ticks(1);
    expect_out("resume_151", 24'h000151, 1, 0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    expect_out("clear_after_run", 24'h000000, 0, 0, 0, 0);

    // Lap.
    press(1, 0, 0);
    ticks(25);
    press(0, 1, 0);
    ticks(30);
    expect_out("lap_frozen", 24'h000025, 1, 1, 0, 1);
    press(0, 1, 0);
    expect_out("lap_release", 24'h000055, 1, 0, 0, 1);
    press(0, 1, 0);
    ticks(5);
    press(1, 0, 0);
    expect_out("lap_to_stop_live", 24'h000060, 0, 0, 0, 1);
    press(0, 1, 0);
    expect_out("lap_clear", 24'h000000, 0, 0, 0, 0);

    // Lap entry coincident with a tick latches the pre-increment value.
    press(1, 0, 0);
    ticks(3);
    press(0, 1, 1);
    expect_out("lap_entry_tick", 24'h000003, 1, 1, 0, 1);
    press(0, 1, 0);
    expect_out("lap_tick_live", 24'h000004, 1, 0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);

    // Simultaneous events.
    press(1, 0, 0);
    ticks(9);
    press(1, 1, 0);
    expect_out("ss_lr_stop", 24'h000009, 0, 0, 0, 1);
    press(1, 0, 0);
    press(1, 1, 1);
    expect_out("ss_lr_tick_stop", 24'h000010, 0, 0, 0, 1);
    press(1, 0, 1);
    expect_out("start_tick_uncounted", 24'h000010, 1, 0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);

    // Carry chain and wrap with a one-minute ceiling.
    press(1, 0, 0);
    ticks(6000);
    expect_out("one_minute", 24'h010000, 1, 0, 0, 1);
    ticks(5999);
    expect_out("max_count", 24'h015999, 1, 0, 0, 1);
    ticks(1);
    expect_out("wrap_overflow", 24'h000000, 1, 0, 1, 1);
    ticks(1);
    expect_out("overflow_sticky", 24'h000001, 1, 0, 1, 1);
    press(1, 0, 0);
    expect_out("overflow_in_stop", 24'h000001, 0, 0, 1, 1);
    press(0, 1, 0);
    expect_out("overflow_cleared", 24'h000000, 0, 0, 0, 0);

    // Asynchronous reset mid-run, checked before any further rising clock edge.
    press(1, 0, 0);
    ticks(5);
    rst = 1'b0;
    #2;
    expect_out("async_reset", 24'h000000, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_stopwatch_ctrl.md
Name: m_stopwatch_ctrl

Overview:
Control FSM and BCD time counter for the L13 stopwatch. Takes the 10 ms square wave from the 10 ms clock generator and two user button levels (start/stop, lap/reset). Sequences run/pause/lap/clear, holds the generator in reset while idle so each run starts on a fresh 10 ms phase, and drives a BCD mm:ss.cc value to the display block.

Parameters:
P_MIN_MAX, 59, highest minute value before wrap (legal range 1..99).

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous reset, active-low.
clk10ms  input  1  10 ms square wave from the generator; synchronous to clk; only its rising edges are used.
i_start_stop  input  1  start/stop button level, debounced upstream.
i_lap_reset  input  1  lap/reset button level, debounced upstream.
o_gen_rst_n  output  1  active-low reset to the 10 ms generator; registered.
o_disp  output  24  {min_t, min_o, sec_t, sec_o, cs_t, cs_o}; 4-bit BCD each; registered.
o_running  output  1  high in RUN or LAP.
o_lap_hold  output  1  high in LAP (display frozen).
o_overflow  output  1  sticky flag: the count has wrapped past P_MIN_MAX:59.99.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, o_disp=0, o_gen_rst_n=0, o_running=0, o_lap_hold=0, o_overflow=0.
- Edge-detect registers for clk10ms, i_start_stop and i_lap_reset reset to 1. A level held high across reset release is not a press or a tick.
- press_ss = i_start_stop & ~prev. press_lr and tick use the same form. All are combinational from the sampled input.
- State and count update on the same clk edge that first samples the input high: 1-cycle latency. Each press acts once regardless of hold length.
- Simultaneous presses: press_ss wins; press_lr is ignored in that cycle.
- FSM (states IDLE, RUN, STOP, LAP):
  - IDLE: press_ss -> RUN. press_lr ignored.
  - RUN: press_ss -> STOP. press_lr -> LAP, capturing the display latch.
  - LAP: press_ss -> STOP, display returns to the live count. press_lr -> RUN, display returns to live.
  - STOP: press_ss -> RUN, resuming from the held count. press_lr -> IDLE, clearing count, display and o_overflow.
- o_gen_rst_n is registered as (next_state != IDLE). The generator leaves reset on the edge that enters RUN from IDLE. It stays out of reset through STOP (phase not restarted on resume).
- Counting rule: the count increments by one centisecond on tick only when the current (pre-transition) state is RUN or LAP. A tick coincident with a stop press is counted. A tick coincident with a start press from STOP/IDLE is not.
- BCD carry chain:
  - cs_o 9->0 carries to cs_t.
  - cs_t 9->0 carries to sec_o.
  - sec_o 9->0 carries to sec_t.
  - sec_t 5->0 carries to minutes.
  - Minutes count 00..P_MIN_MAX in BCD.
  - At P_MIN_MAX:59.99 + tick: count becomes 00:00.00 and o_overflow is set. Set has priority; it is only cleared via STOP->IDLE or reset.
- Display: o_disp = live count in IDLE/RUN/STOP. In LAP it shows the latch captured at the LAP entry edge: the pre-increment value if a tick coincides.
- Count and all digits are never outside BCD range. No other state change occurs without a press.

Test Plan:
1. Reset: pulse rst low mid-sim. Expect o_disp=24'h000000, o_gen_rst_n=0, o_running=0 asynchronously, without waiting for a clk edge.
2. Run/stop: press ss, apply 150 ticks, press ss, apply 40 more ticks. Expect o_disp=24'h000150, o_running=0, o_gen_rst_n=1. Press ss again plus 1 tick gives 24'h000151.
3. Lap:
   - Press ss, apply 25 ticks, press lr, apply 30 ticks: o_disp stays 24'h000025, o_lap_hold=1.
   - Press lr: o_disp=24'h000055.
   - Press ss then lr: o_disp=0, state IDLE, o_gen_rst_n=0.
4. Carry and wrap:
   - Run 6000 ticks: o_disp=24'h010000.
   - Continue to 59:59.99 and apply 1 more tick: o_disp=0, o_overflow=1, o_running=1.
   - Stop plus clear: o_overflow=0.
5. Simultaneous events in RUN at 00:00.09:
   - ss and lr in the same cycle: expect STOP (not LAP).
   - Same cycle also carrying a tick: expect o_disp=24'h000010.
6. Button held across rst release: no state change. A held button yields exactly one transition. Clock-generator integration: first tick arrives 250000 clk cycles after leaving IDLE.
